// File: rtl/main_memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// main_memory_arbiter_pkg
// Shared definitions for the main memory arbiter:
//   - arbState_e : arbiter FSM encodings (idle, port 0 owns, port 1 owns)
//   - ownerMask  : maps an FSM state to the one-hot lock owner it implies
// ---------------------------------------------------------------------------
package main_memory_arbiter_pkg;

  // The two OWN states mean a port has locked the memory for a bounded burst.
  typedef enum logic [1:0] {
    MEM_ARB_IDLE = 2'd0,
    MEM_ARB_OWN0 = 2'd1,
    MEM_ARB_OWN1 = 2'd2
  } arbState_e;

  // One-hot owner vector for a state; idle (and any unused code) owns nothing.
  function automatic logic [1:0] ownerMask(arbState_e s);
    logic [1:0] m;
    m = 2'b00;
    case (s)
      MEM_ARB_OWN0: m = 2'b01;
      MEM_ARB_OWN1: m = 2'b10;
      default:      m = 2'b00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/main_memory_arbiter_rr_priority_select.sv
// ---------------------------------------------------------------------------
// rr_priority_select
// Combinational two-way round-robin pick.
//   req          in  2 : eligible requests, bit i = port i
//   last         in  1 : port that received the most recent grant
//   forced_other in  1 : a lock just expired; the port that is not `last`
//                        must win whenever it is requesting
//   pick         out 2 : one-hot winner, or zero when nobody requests
// ---------------------------------------------------------------------------
module rr_priority_select (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       forced_other,
  output logic [1:0] pick
);

  // The expiry case is handled first so the non-owner is guaranteed the
  // memory without depending on how ties happen to break. Otherwise a lone
  // request wins outright and a tie goes to the port that was not served last.
  always_comb begin
    pick = 2'b00;
    if (forced_other && req[~last]) begin
      pick[~last] = 1'b1;
    end else if (req == 2'b11) begin
      pick[~last] = 1'b1;
    end else begin
      pick = req;
    end
  end

endmodule

// File: rtl/main_memory_arbiter.sv
// ---------------------------------------------------------------------------
// main_memory_arbiter
// Shares the single-ported main memory between the CPU core (port 0) and the
// debug/program-loader port (port 1). Round-robin arbitration, optional
// bounded locking, one access per cycle, registered read data.
//
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   req/we/lock [1:0] : per-port request, write select, lock request
//   addr  [2*ADDR_W]  : port i address at [i*ADDR_W +: ADDR_W]
//   wdata [2*DATA_W]  : port i write data at [i*DATA_W +: DATA_W]
//   gnt   [1:0]       : one-hot grant; access completes at this clock edge
//   rvalid[1:0]       : one-cycle read-data-valid pulse per port
//   rdata             : registered read data shared by both ports
//   owner [1:0]       : one-hot current lock owner, zero when idle
//   mem_raddr/mem_waddr/mem_wdata/mem_wen : drive main_memory
//   mem_rdata         : combinational read data from main_memory
// ---------------------------------------------------------------------------
module main_memory_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [1:0]          lock,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          rvalid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          owner,
  output logic [ADDR_W-1:0]   mem_raddr,
  output logic [ADDR_W-1:0]   mem_waddr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_wen,
  input  logic [DATA_W-1:0]   mem_rdata
);

  import main_memory_arbiter_pkg::*;

  localparam int HoldW = $clog2(MAX_HOLD + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

  arbState_e         state_q, state_d;
  logic              lastPort_q, lastPort_d;
  logic [HoldW-1:0]  holdCnt_q, holdCnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rvalid_q, rvalid_d;

  logic       ownIdx;
  logic       holdExpired;
  logic       arbitrating;
  logic       forcedOther;
  logic [1:0] pick;
  logic [1:0] gntRaw;
  logic       grantIdx;

  // While a port owns the memory, last always equals the owner, because only
  // the owner can be granted during a hold. That lets the selector treat
  // "not last" as "not the owner" on the expiry cycle.
  assign ownIdx      = (state_q == MEM_ARB_OWN1);
  assign holdExpired = (holdCnt_q == HoldMax);
  assign arbitrating = (state_q == MEM_ARB_IDLE) || !lock[ownIdx] || holdExpired;
  assign forcedOther = (state_q != MEM_ARB_IDLE) && holdExpired;

  rr_priority_select u_select (
    .req          (req),
    .last         (lastPort_q),
    .forced_other (forcedOther),
    .pick         (pick)
  );

  // Grant selection: the round-robin pick when arbitrating, otherwise only
  // the owner may go. Grants are suppressed outright during reset so nothing
  // reaches the memory while rst is high.
  always_comb begin
    gntRaw = 2'b00;
    if (arbitrating) begin
      gntRaw = pick;
    end else begin
      gntRaw = req & ownerMask(state_q);
    end
    gnt      = rst ? 2'b00 : gntRaw;
    grantIdx = gnt[1];
  end

  // Memory-side datapath steered by the granted port; port 0 is the default
  // address source when nothing is granted.
  always_comb begin
    mem_raddr = grantIdx ? addr[ADDR_W +: ADDR_W] : addr[0 +: ADDR_W];
    mem_waddr = mem_raddr;
    mem_wdata = grantIdx ? wdata[DATA_W +: DATA_W] : wdata[0 +: DATA_W];
    mem_wen   = (|gnt) & we[grantIdx];
  end

  // Next-state logic for the FSM, the round-robin pointer, the hold counter
  // and the read-return registers.
  always_comb begin
    state_d    = state_q;
    holdCnt_d  = holdCnt_q;
    lastPort_d = lastPort_q;
    rvalid_d   = gnt & ~we;
    rdata_d    = (|rvalid_d) ? mem_rdata : rdata_q;

    if (|gnt) begin
      lastPort_d = grantIdx;
    end

    if (arbitrating) begin
      if ((|gnt) && lock[grantIdx]) begin
        state_d   = grantIdx ? MEM_ARB_OWN1 : MEM_ARB_OWN0;
        holdCnt_d = HoldW'(1);
      end else begin
        state_d   = MEM_ARB_IDLE;
        holdCnt_d = '0;
      end
    end else begin
      holdCnt_d = holdCnt_q + HoldW'(1);
    end
  end

  // State registers. Reset leaves port 1 as "last" so port 0 wins the
  // first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= MEM_ARB_IDLE;
      lastPort_q <= 1'b1;
      holdCnt_q  <= '0;
      rdata_q    <= '0;
      rvalid_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      lastPort_q <= lastPort_d;
      holdCnt_q  <= holdCnt_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign owner  = ownerMask(state_q);

endmodule

// File: tb/tb_main_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_main_memory_arbiter
// Directed testbench for main_memory_arbiter with MAX_HOLD = 4 and a small
// behavioural model of main_memory (16 words, combinational read).
// ---------------------------------------------------------------------------
module tb_main_memory_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [1:0]  lock;
  logic [63:0] addr;
  logic [63:0] wdata;
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [31:0] rdata;
  logic [1:0]  owner;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_wen;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:15];
  logic        memInit;

  int checks;
  int errors;

  main_memory_arbiter #(
    .DATA_W   (32),
    .ADDR_W   (32),
    .MAX_HOLD (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .lock      (lock),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .owner     (owner),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wen   (mem_wen),
    .mem_rdata (mem_rdata)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: preloaded with 0xA000_0000 + index, written on the rising
  // edge when the arbiter asserts mem_wen.
  always @(posedge clk or posedge memInit) begin
    if (memInit) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else if (mem_wen && (mem_waddr < 32'd16)) begin
      mem[mem_waddr[3:0]] <= mem_wdata;
    end
  end

  always_comb begin
    mem_rdata = (mem_raddr < 32'd16) ? mem[mem_raddr[3:0]] : 32'h0;
  end

  // Drive one cycle's worth of inputs just after the falling edge, then let
  // the combinational outputs settle.
  task automatic applyStimulus(input logic [1:0] r, input logic [1:0] w, input logic [1:0] l,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] d0, input logic [31:0] d1);
    @(negedge clk);
    req   = r;
    we    = w;
    lock  = l;
    addr  = {a1, a0};
    wdata = {d1, d0};
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst  = 1'b1;
    req  = 2'b00;
    we   = 2'b00;
    lock = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    applyStimulus(2'b00, 2'b00, 2'b00, 32'd3, 32'd7, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b expected 00", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 00000000", rdata); end
    checks++; if (owner !== 2'b00) begin errors++; $display("[TB] FAIL reset_owner: got %b expected 00", owner); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_wen: got %b expected 0", mem_wen); end
    checks++; if (mem_raddr !== 32'd3) begin errors++; $display("[TB] FAIL idle_raddr: got %0d expected 3", mem_raddr); end
  endtask

  task automatic test_write_read();
    doReset();
    applyStimulus(2'b01, 2'b01, 2'b00, 32'd5, 32'd0, 32'hDEAD_BEEF, 32'h0);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL wr_gnt: got %b expected 01", gnt); end
    checks++; if (mem_wen !== 1'b1) begin errors++; $display("[TB] FAIL wr_wen: got %b expected 1", mem_wen); end
    checks++; if (mem_waddr !== 32'd5) begin errors++; $display("[TB] FAIL wr_waddr: got %0d expected 5", mem_waddr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL wr_wdata: got %h expected deadbeef", mem_wdata); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL wr_rvalid: got %b expected 00", rvalid); end
    applyStimulus(2'b01, 2'b00, 2'b00, 32'd5, 32'd0, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rd_gnt: got %b expected 01", gnt); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL rd_wen: got %b expected 0", mem_wen); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL rd_rvalid: got %b expected 01", rvalid); end
    checks++; if (rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL rd_rdata: got %h expected deadbeef", rdata); end
    applyStimulus(2'b00, 2'b00, 2'b00, 32'd0, 32'd0, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rd_pulse: got %b expected 00", rvalid); end
  endtask

  task automatic test_tie();
    logic [1:0]  expGnt [0:2];
    logic [31:0] expData [0:2];
    expGnt[0] = 2'b01; expGnt[1] = 2'b10; expGnt[2] = 2'b01;
    expData[0] = 32'hA000_0002; expData[1] = 32'hA000_0003; expData[2] = 32'hA000_0002;
    doReset();
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b11, 2'b00, 2'b00, 32'd2, 32'd3, 32'h0, 32'h0);
      checks++; if (gnt !== expGnt[c]) begin errors++; $display("[TB] FAIL tie_gnt[%0d]: got %b expected %b", c, gnt, expGnt[c]); end
      @(posedge clk); #1;
      checks++; if (rvalid !== expGnt[c]) begin errors++; $display("[TB] FAIL tie_rvalid[%0d]: got %b expected %b", c, rvalid, expGnt[c]); end
      checks++; if (rdata !== expData[c]) begin errors++; $display("[TB] FAIL tie_rdata[%0d]: got %h expected %h", c, rdata, expData[c]); end
    end
  endtask

  // Reset, then one solo port-0 read so that port 1 is next in line on a tie.
  task automatic preludePort0Last();
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00, 32'd1, 32'd4, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL prelude_gnt: got %b expected 01", gnt); end
  endtask

  task automatic test_bounded_lock();
    logic [1:0] expGnt [0:4];
    logic [1:0] expOwner [0:4];
    expGnt[0] = 2'b10; expGnt[1] = 2'b10; expGnt[2] = 2'b10; expGnt[3] = 2'b10; expGnt[4] = 2'b01;
    expOwner[0] = 2'b00; expOwner[1] = 2'b10; expOwner[2] = 2'b10; expOwner[3] = 2'b10; expOwner[4] = 2'b10;
    preludePort0Last();
    for (int c = 0; c < 5; c++) begin
      applyStimulus(2'b11, 2'b00, 2'b10, 32'd1, 32'd4, 32'h0, 32'h0);
      checks++; if (gnt !== expGnt[c]) begin errors++; $display("[TB] FAIL lock_gnt[%0d]: got %b expected %b", c, gnt, expGnt[c]); end
      checks++; if (owner !== expOwner[c]) begin errors++; $display("[TB] FAIL lock_owner[%0d]: got %b expected %b", c, owner, expOwner[c]); end
    end
    applyStimulus(2'b00, 2'b00, 2'b00, 32'd1, 32'd4, 32'h0, 32'h0);
    checks++; if (owner !== 2'b00) begin errors++; $display("[TB] FAIL lock_release_owner: got %b expected 00", owner); end
  endtask

  task automatic test_early_unlock();
    preludePort0Last();
    applyStimulus(2'b11, 2'b00, 2'b10, 32'd1, 32'd4, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL unlock_gnt1: got %b expected 10", gnt); end
    applyStimulus(2'b11, 2'b00, 2'b10, 32'd1, 32'd4, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL unlock_gnt2: got %b expected 10", gnt); end
    checks++; if (owner !== 2'b10) begin errors++; $display("[TB] FAIL unlock_owner_held: got %b expected 10", owner); end
    applyStimulus(2'b11, 2'b00, 2'b00, 32'd1, 32'd4, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL unlock_gnt3: got %b expected 01", gnt); end
    @(posedge clk); #1;
    checks++; if (owner !== 2'b00) begin errors++; $display("[TB] FAIL unlock_owner_free: got %b expected 00", owner); end
  endtask

  task automatic test_reset_mid_read();
    doReset();
    applyStimulus(2'b01, 2'b00, 2'b00, 32'd5, 32'd0, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rstmid_gnt: got %b expected 01", gnt); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL rstmid_rvalid_pre: got %b expected 01", rvalid); end
    rst   = 1'b1;
    req   = 2'b01;
    we    = 2'b01;
    addr  = {32'd0, 32'd6};
    wdata = {32'h0, 32'hFFFF_FFFF};
    #1;
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_rvalid: got %b expected 00", rvalid); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("[TB] FAIL rstmid_rdata: got %h expected 00000000", rdata); end
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL rstmid_gnt_forced: got %b expected 00", gnt); end
    checks++; if (mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_wen_forced: got %b expected 0", mem_wen); end
    @(posedge clk); #1;
    checks++; if (mem[6] !== 32'hA000_0006) begin errors++; $display("[TB] FAIL rstmid_nowrite: got %h expected a0000006", mem[6]); end
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(2'b10, 2'b10, 2'b00, 32'd0, 32'd9, 32'h0, 32'h1234_5678);
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL rstmid_p1_gnt: got %b expected 10", gnt); end
    checks++; if (mem_waddr !== 32'd9) begin errors++; $display("[TB] FAIL rstmid_p1_waddr: got %0d expected 9", mem_waddr); end
    @(posedge clk); #1;
    checks++; if (mem[9] !== 32'h1234_5678) begin errors++; $display("[TB] FAIL rstmid_mem9: got %h expected 12345678", mem[9]); end
  endtask

  task automatic test_idle_owner();
    doReset();
    applyStimulus(2'b11, 2'b00, 2'b01, 32'd2, 32'd3, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL idleown_take: got %b expected 01", gnt); end
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b10, 2'b00, 2'b01, 32'd2, 32'd3, 32'h0, 32'h0);
      checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL idleown_wait[%0d]: got %b expected 00", c, gnt); end
      checks++; if (owner !== 2'b01) begin errors++; $display("[TB] FAIL idleown_owner[%0d]: got %b expected 01", c, owner); end
    end
    applyStimulus(2'b10, 2'b00, 2'b01, 32'd2, 32'd3, 32'h0, 32'h0);
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL idleown_expire: got %b expected 10", gnt); end
    checks++; if (mem_raddr !== 32'd3) begin errors++; $display("[TB] FAIL idleown_raddr: got %0d expected 3", mem_raddr); end
    @(posedge clk); #1;
    checks++; if (rvalid !== 2'b10) begin errors++; $display("[TB] FAIL idleown_rvalid: got %b expected 10", rvalid); end
    checks++; if (rdata !== 32'hA000_0003) begin errors++; $display("[TB] FAIL idleown_rdata: got %h expected a0000003", rdata); end
  endtask

  // Test sequence; each test starts from its own reset.
  initial begin
    checks  = 0;
    errors  = 0;
    rst     = 1'b1;
    req     = 2'b00;
    we      = 2'b00;
    lock    = 2'b00;
    addr    = '0;
    wdata   = '0;
    memInit = 1'b1;
    #1 memInit = 1'b0;
    $display("[TB] starting main_memory_arbiter tests");
    test_reset();
    test_write_read();
    test_tie();
    test_bounded_lock();
    test_early_unlock();
    test_reset_mid_read();
    test_idle_owner();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
